// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; misses refill a whole line byte-by-byte from RAM.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module icache #(
    parameter int unsigned INDEX_WIDTH = 4,
    parameter int unsigned LINE_WIDTH  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_result,
    input  logic        if_clear,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    output logic        ram_req,
    input  logic        ram_gnt,
    output logic [31:0] ram_a,
    input  logic [7:0]  ram_din
);

    localparam int unsigned LINES  = 1 << INDEX_WIDTH;
    localparam int unsigned LBYTES = 1 << LINE_WIDTH;
    localparam int unsigned LBITS  = LBYTES * 8;
    localparam int unsigned TAG_W  = 32 - INDEX_WIDTH - LINE_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, REFILL, RESP} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic                    ready_q, ready_d;
    logic [31:0]             result_q, result_d;
    logic                    req_q, req_d;
    logic [31:0]             ram_a_q, ram_a_d;
    logic [LINE_WIDTH:0]     bcnt_q, bcnt_d;
    logic [LBITS-1:0]        linebuf_q, linebuf_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [LBITS-1:0]        data_q [LINES];
    logic                    wr_en;
    logic                    hit_inc, miss_inc;

    logic [INDEX_WIDTH-1:0]  in_idx, req_idx;
    logic [TAG_W-1:0]        in_tag;
    logic [LINE_WIDTH-1:0]   in_boff, req_boff, cap_idx;
    logic                    hit;

    assign in_idx   = if_addr[LINE_WIDTH +: INDEX_WIDTH];
    assign in_tag   = if_addr[31 -: TAG_W];
    assign in_boff  = if_addr[LINE_WIDTH-1:0] & ~LINE_WIDTH'(3);
    assign req_idx  = addr_q[LINE_WIDTH +: INDEX_WIDTH];
    assign req_boff = addr_q[LINE_WIDTH-1:0] & ~LINE_WIDTH'(3);
    assign hit      = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
    // Byte arriving on ram_din belongs to the address issued one active cycle earlier.
    assign cap_idx  = LINE_WIDTH'(bcnt_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ready_d   = ready_q;
        result_d  = result_q;
        req_d     = req_q;
        ram_a_d   = ram_a_q;
        bcnt_d    = bcnt_q;
        linebuf_d = linebuf_q;
        valid_d   = valid_q;
        wr_en     = 1'b0;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        if (if_clear) begin
            state_d = IDLE;
            ready_d = 1'b0;
            req_d   = 1'b0;
        end else if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    ready_d = 1'b0;
                    if (if_valid) begin
                        addr_d = if_addr;
                        if (hit) begin
                            ready_d  = 1'b1;
                            result_d = data_q[in_idx][{in_boff, 3'b000} +: 32];
                            hit_inc  = 1'b1;
                        end else begin
                            state_d  = WAIT_GNT;
                            req_d    = 1'b1;
                            miss_inc = 1'b1;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (ram_gnt) begin
                        ram_a_d = {addr_q[31:LINE_WIDTH], LINE_WIDTH'(0)};
                        bcnt_d  = '0;
                        state_d = REFILL;
                    end
                end
                REFILL: begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q != '0)
                        linebuf_d[{cap_idx, 3'b000} +: 8] = ram_din;
                    if (bcnt_q < (LINE_WIDTH+1)'(LBYTES - 1))
                        ram_a_d = ram_a_q + 32'd1;
                    if (bcnt_q == (LINE_WIDTH+1)'(LBYTES)) begin
                        wr_en            = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        req_d            = 1'b0;
                        state_d          = RESP;
                    end
                end
                RESP: begin
                    ready_d  = 1'b1;
                    result_d = linebuf_q[{req_boff, 3'b000} +: 32];
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            ready_q   <= 1'b0;
            result_q  <= '0;
            req_q     <= 1'b0;
            ram_a_q   <= '0;
            bcnt_q    <= '0;
            linebuf_q <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
            req_q     <= req_d;
            ram_a_q   <= ram_a_d;
            bcnt_q    <= bcnt_d;
            linebuf_q <= linebuf_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && wr_en) begin
            data_q[req_idx] <= linebuf_d;
            tag_q[req_idx]  <= addr_q[31 -: TAG_W];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_inc)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss_inc)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    assign if_ready  = ready_q;
    assign if_result = result_q;
    assign ram_req   = req_q;
    assign ram_a     = ram_a_q;

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: refill timing, hits, freeze and flush behaviour.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, if_valid, if_clear, ram_gnt;
    logic [31:0] if_addr;
    logic        if_ready, ram_req;
    logic [31:0] if_result, ram_a;
    logic [7:0]  ram_din;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    logic [7:0]  mem [4096];
    int          n_checks = 0;
    int          n_fail   = 0;

    icache #(.INDEX_WIDTH(4), .LINE_WIDTH(4)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .if_valid  (if_valid),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_result (if_result),
        .if_clear  (if_clear),
`ifdef ICACHE_STATS_EN
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
`endif
        .ram_req   (ram_req),
        .ram_gnt   (ram_gnt),
        .ram_a     (ram_a),
        .ram_din   (ram_din)
    );

    always #5 clk_in = ~clk_in;

    // RAM returns the byte addressed in the previous active cycle.
    always @(posedge clk_in)
        if (rdy_in)
            ram_din <= mem[ram_a[11:0]];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_hit(input logic [31:0] addr, input logic [31:0] expw);
        if_valid = 1'b1;
        if_addr  = addr;
        tick();
        if_valid = 1'b0;
        check("hit_ready", {31'd0, if_ready}, 32'd1);
        check("hit_word", if_result, expw);
        check("hit_noreq", {31'd0, ram_req}, 32'd0);
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [31:0] expw,
                           input int freeze_at, input int clear_at);
        logic [31:0] base;
        int          n;
        int          stale;
        logic        got;
        base     = addr & ~32'hF;
        if_valid = 1'b1;
        if_addr  = addr;
        tick();
        if_valid = 1'b0;
        if_addr  = 32'hDEAD_BEE0;
        check("miss_req", {31'd0, ram_req}, 32'd1);
        check("miss_noready", {31'd0, if_ready}, 32'd0);
        tick();
        check("wait_gnt_req", {31'd0, ram_req}, 32'd1);
        ram_gnt = 1'b1;
        tick();
        check("ram_a_base", ram_a, base);
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            if (n == freeze_at) begin
                rdy_in = 1'b0;
                repeat (3) tick();
                check("freeze_ram_a", ram_a, base + 32'(freeze_at));
                rdy_in = 1'b1;
            end
            if (n == clear_at) begin
                if_clear = 1'b1;
                tick();
                if_clear = 1'b0;
                check("clear_req", {31'd0, ram_req}, 32'd0);
                check("clear_ready", {31'd0, if_ready}, 32'd0);
                ram_gnt = 1'b0;
                stale   = 0;
                repeat (20) begin
                    tick();
                    if (if_ready) stale++;
                end
                check("clear_stale", 32'(stale), 32'd0);
                return;
            end
            tick();
            n++;
            if (n == 1)  check("ram_a_step1", ram_a, base + 32'd1);
            if (n == 15) check("ram_a_last", ram_a, base + 32'd15);
            got = if_ready;
        end
        check("refill_latency", 32'(n), 32'd18);
        check("refill_word", if_result, expw);
        check("refill_req_drop", {31'd0, ram_req}, 32'd0);
        ram_gnt = 1'b0;
        tick();
        check("resp_one_cycle", {31'd0, if_ready}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) + 8'(i >> 8);
        mem[0]  = 8'h13; mem[1]  = 8'h05; mem[2]  = 8'h00; mem[3]  = 8'h00;
        mem[4]  = 8'h93; mem[5]  = 8'h00; mem[6]  = 8'h10; mem[7]  = 8'h00;
        mem[8]  = 8'h13; mem[9]  = 8'h01; mem[10] = 8'h20; mem[11] = 8'h00;
        mem[12] = 8'h93; mem[13] = 8'h01; mem[14] = 8'h30; mem[15] = 8'h00;

        rst_in = 1'b1; rdy_in = 1'b1; if_valid = 1'b0; if_addr = '0;
        if_clear = 1'b0; ram_gnt = 1'b0;
        repeat (3) tick();
        check("rst_ready", {31'd0, if_ready}, 32'd0);
        check("rst_result", if_result, 32'd0);
        check("rst_req", {31'd0, ram_req}, 32'd0);
        check("rst_ram_a", ram_a, 32'd0);
        rst_in = 1'b0;
        tick();

        do_miss(32'h0, 32'h0000_0513, -1, -1);

        // Back-to-back hits: a request alongside if_ready is a new request.
        if_valid = 1'b1;
        if_addr  = 32'h4; tick();
        check("b2b_ready0", {31'd0, if_ready}, 32'd1);
        check("b2b_word0", if_result, 32'h0010_0093);
        if_addr  = 32'h8; tick();
        check("b2b_ready1", {31'd0, if_ready}, 32'd1);
        check("b2b_word1", if_result, 32'h0020_0113);
        if_addr  = 32'hF; tick();
        check("b2b_ready2", {31'd0, if_ready}, 32'd1);
        check("b2b_word2", if_result, 32'h0030_0193);
        check("b2b_noreq", {31'd0, ram_req}, 32'd0);
        if_valid = 1'b0;
        tick();
        check("b2b_idle", {31'd0, if_ready}, 32'd0);

        do_miss(32'h104, 32'h0807_0605, -1, -1);
        do_hit(32'h10C, 32'h100F_0E0D);
        do_miss(32'h0, 32'h0000_0513, 5, -1);

`ifdef ICACHE_STATS_EN
        check("stat_miss", miss_cnt, 32'd3);
        check("stat_hit", hit_cnt, 32'd4);
`endif

        // if_ready held through a freeze until rdy_in returns.
        if_valid = 1'b1;
        if_addr  = 32'h4;
        tick();
        if_valid = 1'b0;
        rdy_in   = 1'b0;
        check("frz_ready0", {31'd0, if_ready}, 32'd1);
        tick(); tick();
        check("frz_ready_held", {31'd0, if_ready}, 32'd1);
        check("frz_word_held", if_result, 32'h0010_0093);
        rdy_in = 1'b1;
        tick();
        check("frz_ready_drop", {31'd0, if_ready}, 32'd0);

        do_miss(32'h200, 32'h0, -1, 7);
        do_hit(32'h8, 32'h0020_0113);
        do_miss(32'h48, 32'h4B4A_4948, -1, -1);
        do_miss(32'h20C, 32'h1110_0F0E, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
